inst_fetch_bridge: RTL and testbench

Instruction-side memory responder for the dual-issue front end. It takes the fetch PC driven by the IF stage and fetches the instruction pair at pc and pc+4 over a single-port SRAM-like bus (request/address-ok/data-ok). It returns both words to IF, holds IF with `delay_hard` until the pair for the current PC is ready, and flags misaligned fetch addresses for the exception logic.

---
 rtl/inst_fetch_bridge.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction-pair fetch responder: fetches {pc, pc+4} over a request/addr_ok/data_ok bus
// and stalls IF until the pair tagged with the current pc is held in the output registers.
module inst_fetch_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] if_inst_1,
    output logic [31:0] if_inst_2,
    output logic        delay_hard,
    output logic        IADEE,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        WAIT_A = 3'd2,
        REQ_B  = 3'd3,
        WAIT_B = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    state_t      state_r;
    logic        tag_valid_r;
    logic [31:0] served_pc_r;
    logic [31:0] fetch_pc_r;
    logic [31:0] hold_r;
    logic        hit_s;
    logic [31:0] next_pc_s;

    // kseg0/kseg1 fold onto the low 512 MB of physical space; everything else is unmapped
    function automatic logic [31:0] xlate(input logic [31:0] a);
        logic [31:0] r;
        if (a[31:30] == 2'b10) begin
            r = {3'b000, a[28:0]};
        end else begin
            r = a;
        end
        return r;
    endfunction

    assign hit_s      = tag_valid_r && (served_pc_r == pc);
    assign delay_hard = !hit_s;
    assign next_pc_s  = fetch_pc_r + 32'd4;

    // Fetch sequencer: tag, bus request and output registers all advance here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            tag_valid_r <= 1'b0;
            served_pc_r <= 32'h0000_0000;
            fetch_pc_r  <= 32'h0000_0000;
            hold_r      <= 32'h0000_0000;
            if_inst_1   <= 32'h0000_0000;
            if_inst_2   <= 32'h0000_0000;
            IADEE       <= 1'b0;
            inst_req    <= 1'b0;
            inst_addr   <= 32'h0000_0000;
        end else begin
            if (flush) begin
                tag_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (!flush && !hit_s) begin
                        if (pc[1:0] != 2'b00) begin
                            if_inst_1   <= 32'h0000_0000;
                            if_inst_2   <= 32'h0000_0000;
                            IADEE       <= 1'b1;
                            served_pc_r <= pc;
                            tag_valid_r <= 1'b1;
                        end else begin
                            fetch_pc_r <= pc;
                            inst_req   <= 1'b1;
                            inst_addr  <= xlate(pc);
                            state_r    <= REQ_A;
                        end
                    end
                end
                REQ_A: begin
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        state_r  <= flush ? DRAIN : WAIT_A;
                    end else if (flush) begin
                        inst_req <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                // data arriving together with flush is already consumed, so no drain is needed
                WAIT_A: begin
                    if (inst_data_ok) begin
                        if (flush) begin
                            state_r <= IDLE;
                        end else begin
                            hold_r    <= inst_rdata;
                            inst_req  <= 1'b1;
                            inst_addr <= xlate(next_pc_s);
                            state_r   <= REQ_B;
                        end
                    end else if (flush) begin
                        state_r <= DRAIN;
                    end
                end
                REQ_B: begin
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        state_r  <= flush ? DRAIN : WAIT_B;
                    end else if (flush) begin
                        inst_req <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                WAIT_B: begin
                    if (inst_data_ok) begin
                        if (!flush) begin
                            if_inst_1   <= hold_r;
                            if_inst_2   <= inst_rdata;
                            IADEE       <= 1'b0;
                            served_pc_r <= fetch_pc_r;
                            tag_valid_r <= 1'b1;
                        end
                        state_r <= IDLE;
                    end else if (flush) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inst_data_ok) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    inst_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed vector table, hand-written flush/reset sequences,
// then randomized pc/flush traffic against a latency-randomized bus and a pair-content model.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] if_inst_1;
    logic [31:0] if_inst_2;
    logic        delay_hard;
    logic        IADEE;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    inst_fetch_bridge dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush),
        .if_inst_1(if_inst_1), .if_inst_2(if_inst_2), .delay_hard(delay_hard), .IADEE(IADEE),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory contents: two fixed boot words, everything else a function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h2408_0001;
        else if (a == 32'h1FC0_0004) return 32'h2409_0002;
        else return {a[15:0], a[31:16]} ^ 32'h3C5A_0F0F;
    endfunction

    function automatic logic [31:0] phys(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a & 32'h1FFF_FFFF;
        else return a;
    endfunction

    // ---------------- bus model ----------------
    logic [31:0] addr_log[$];
    logic [31:0] pend_addr;
    int  data_cnt = 0;
    int  req_age  = 0;
    int  cur_la   = 0;
    int  fix_la   = 0;
    int  fix_ld   = 1;
    bit  rand_bus = 1'b0;
    bit  busy;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = 32'h0;
            data_cnt     = 0;
            req_age      = 0;
        end else begin
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            busy = (data_cnt != 0);
            if (data_cnt != 0) begin
                data_cnt--;
                if (data_cnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(pend_addr);
                end
            end
            if (inst_req && !busy) begin
                if (req_age == 0) cur_la = rand_bus ? int'($urandom_range(0, 2)) : fix_la;
                if (req_age >= cur_la) begin
                    inst_addr_ok = 1'b1;
                    pend_addr    = inst_addr;
                    data_cnt     = rand_bus ? int'($urandom_range(1, 3)) : fix_ld;
                    req_age      = 0;
                    addr_log.push_back(inst_addr);
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] pc;
        int          nreq;
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] i1;
        logic [31:0] i2;
        logic        iadee;
        int          lat;
    } vec_t;

    localparam int NV = 6;
    vec_t v[NV];

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        logic [31:0] r;
        case ($urandom_range(0, 4))
            0:       base = 32'hBFC0_0000;
            1:       base = 32'h8000_0000;
            2:       base = 32'h0040_0000;
            3:       base = 32'hFFFF_FFF0;
            default: base = 32'hA000_0000;
        endcase
        r = base + (32'($urandom_range(0, 3)) << 2);
        if ($urandom_range(0, 5) == 0) r[1:0] = 2'($urandom_range(1, 3));
        return r;
    endfunction

    int          lat;
    int          k;
    int          stall;
    int          r;
    logic [31:0] e1;
    logic [31:0] e2;

    initial begin
        v[0] = '{32'hBFC0_0000, 2, 32'h1FC0_0000, 32'h1FC0_0004, 32'h2408_0001, 32'h2409_0002, 1'b0, 5};
        v[1] = '{32'hBFC0_0002, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1};
        v[2] = '{32'hFFFF_FFFC, 2, 32'hFFFF_FFFC, 32'h0000_0000,
                 mem_word(32'hFFFF_FFFC), mem_word(32'h0000_0000), 1'b0, 5};
        v[3] = '{32'h8000_0010, 2, 32'h0000_0010, 32'h0000_0014,
                 mem_word(32'h0000_0010), mem_word(32'h0000_0014), 1'b0, 5};
        v[4] = '{32'h0040_0000, 2, 32'h0040_0000, 32'h0040_0004,
                 mem_word(32'h0040_0000), mem_word(32'h0040_0004), 1'b0, 5};
        v[5] = '{32'hA000_1000, 2, 32'h0000_1000, 32'h0000_1004,
                 mem_word(32'h0000_1000), mem_word(32'h0000_1004), 1'b0, 5};

        reset = 1'b1;
        flush = 1'b0;
        pc    = 32'hBFC0_0000;
        repeat (3) @(negedge clk);
        chk("rst_dh",   32'(delay_hard), 32'd1);
        chk("rst_i1",   if_inst_1, 32'h0);
        chk("rst_i2",   if_inst_2, 32'h0);
        chk("rst_iadee", 32'(IADEE), 32'd0);
        chk("rst_req",  32'(inst_req), 32'd0);
        chk("rst_addr", inst_addr, 32'h0);
        reset = 1'b0;

        // zero-wait bus for the vector table
        for (int i = 0; i < NV; i++) begin
            addr_log.delete();
            pc = v[i].pc;
            #1;
            chk("miss_dh", 32'(delay_hard), 32'd1);
            lat = 0;
            while (delay_hard === 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", lat, v[i].lat);
            chk("inst_1", if_inst_1, v[i].i1);
            chk("inst_2", if_inst_2, v[i].i2);
            chk("iadee", 32'(IADEE), 32'(v[i].iadee));
            chk("nreq", addr_log.size(), v[i].nreq);
            if (v[i].nreq == 2 && addr_log.size() == 2) begin
                chk("addr_a", addr_log[0], v[i].addr_a);
                chk("addr_b", addr_log[1], v[i].addr_b);
            end
            if (i == 0) begin
                repeat (4) begin
                    @(negedge clk);
                    chk("hold_req", 32'(inst_req), 32'd0);
                    chk("hold_dh", 32'(delay_hard), 32'd0);
                end
            end
            @(negedge clk);
        end

        // slow bus, flush in WAIT_A while pc moves: first data must be discarded
        fix_la = 2;
        fix_ld = 3;
        addr_log.delete();
        pc = 32'hBFC0_0010;
        k = 0;
        while (addr_log.size() == 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        flush = 1'b1;
        pc    = 32'hBFC0_0100;
        @(negedge clk);
        flush = 1'b0;
        k = 0;
        while (delay_hard === 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("fl_done", 32'(delay_hard), 32'd0);
        chk("fl_nreq", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            chk("fl_addr0", addr_log[0], 32'h1FC0_0010);
            chk("fl_addr1", addr_log[1], 32'h1FC0_0100);
            chk("fl_addr2", addr_log[2], 32'h1FC0_0104);
        end
        chk("fl_i1", if_inst_1, mem_word(32'h1FC0_0100));
        chk("fl_i2", if_inst_2, mem_word(32'h1FC0_0104));

        // reset while waiting for the second word
        fix_la = 0;
        fix_ld = 3;
        addr_log.delete();
        pc = 32'h8000_0200;
        k = 0;
        while (addr_log.size() < 2 && k < 30) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mr_i1", if_inst_1, 32'h0);
        chk("mr_i2", if_inst_2, 32'h0);
        chk("mr_iadee", 32'(IADEE), 32'd0);
        chk("mr_req", 32'(inst_req), 32'd0);
        chk("mr_dh", 32'(delay_hard), 32'd1);
        repeat (2) @(negedge clk);
        fix_ld = 1;
        addr_log.delete();
        reset = 1'b0;
        #1;
        chk("mr_dh_rel", 32'(delay_hard), 32'd1);
        lat = 0;
        while (delay_hard === 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("mr_lat", lat, 5);
        chk("mr_nreq", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk("mr_addr0", addr_log[0], 32'h0000_0200);
            chk("mr_addr1", addr_log[1], 32'h0000_0204);
        end
        chk("mr_new_i1", if_inst_1, mem_word(32'h0000_0200));
        chk("mr_new_i2", if_inst_2, mem_word(32'h0000_0204));

        // randomized traffic: any unstalled cycle must present the pair for the current pc
        rand_bus = 1'b1;
        stall = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            flush = 1'b0;
            if (delay_hard === 1'b0) begin
                stall = 0;
                if (pc[1:0] != 2'b00) begin
                    e1 = 32'h0;
                    e2 = 32'h0;
                end else begin
                    e1 = mem_word(phys(pc));
                    e2 = mem_word(phys(pc + 32'd4));
                end
                chk("rnd_i1", if_inst_1, e1);
                chk("rnd_i2", if_inst_2, e2);
                chk("rnd_iadee", 32'(IADEE), {31'd0, pc[1:0] != 2'b00});
            end else begin
                stall++;
                if (stall > 80) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rnd_stall: stalled %0d cycles, expected at most 80", stall);
                    stall = 0;
                end
            end
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                flush = 1'b1;
                stall = 0;
            end else if (r <= (delay_hard ? 1 : 6)) begin
                pc = rand_pc();
                stall = 0;
            end
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
